mod_wave_gen: RTL and testbench

- Upstream modulating-source stage for the FM chain. Generates the 14-bit offset-binary modulating signal that drives the FM block's modulating input, alongside that block's 16-bit deviation word and 24-bit carrier word.
- Phase-accumulator waveform generator: sawtooth, triangle, square or DC, with amplitude scaling.
- Configuration arrives over a valid/ready handshake and is applied glitch-free at the next phase wrap.

---
 rtl/mod_wave_gen_pkg.sv | 22 ++
 rtl/mod_wave_shape.sv | 55 +++++
 rtl/mod_wave_gen.sv | 123 ++++++++++++
 tb/tb_mod_wave_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_wave_gen_pkg.sv
// Shared constants and types for the modulating-source waveform generator.
// Wave-select encodings, offset-binary midpoint and the config FSM state type.
package mod_wave_gen_pkg;

    localparam int PHASE_W = 24;
    localparam int OUT_W   = 14;
    localparam int AMP_W   = 14;

    localparam logic [1:0] WAVE_DC  = 2'd0;
    localparam logic [1:0] WAVE_SAW = 2'd1;
    localparam logic [1:0] WAVE_TRI = 2'd2;
    localparam logic [1:0] WAVE_SQR = 2'd3;

    localparam logic [13:0] MID_SCALE = 14'h2000;
    localparam logic [13:0] AMP_UNITY = 14'd8192;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/mod_wave_shape.sv
// Waveform select (S2) and signed amplitude scaling (S3), both registered.
// Shape and amplitude travel together through S2 so a sample never mixes configs.
module mod_wave_shape #(
    parameter int OUT_W = mod_wave_gen_pkg::OUT_W,
    parameter int AMP_W = mod_wave_gen_pkg::AMP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OUT_W:0]   phase_hi,
    input  logic [1:0]       wave,
    input  logic [AMP_W-1:0] amp,
    output logic [OUT_W-1:0] y
);
    import mod_wave_gen_pkg::*;

    localparam int PW = OUT_W + AMP_W + 1;

    logic [OUT_W-1:0]        p;
    logic [OUT_W-1:0]        u;
    logic [OUT_W-1:0]        shape;
    logic [OUT_W-1:0]        shape_q;
    logic [AMP_W-1:0]        amp_q;
    logic signed [OUT_W-1:0] s;
    logic signed [PW-1:0]    prod;

    // phase_hi carries phase[MSB:MSB-OUT_W]; p and u are the two overlapping windows.
    always_comb begin
        p = phase_hi[OUT_W:1];
        u = phase_hi[OUT_W-1:0];
        case (wave)
            WAVE_SAW: shape = p;
            WAVE_TRI: shape = phase_hi[OUT_W] ? ~u : u;
            WAVE_SQR: shape = phase_hi[OUT_W] ? '0 : '1;
            default:  shape = OUT_W'(MID_SCALE);
        endcase
    end

    // Offset binary to two's complement is a flip of the MSB.
    assign s    = $signed(shape_q ^ OUT_W'(MID_SCALE));
    assign prod = PW'(s) * PW'($signed({1'b0, amp_q}));

    always_ff @(posedge clk) begin
        if (rst) begin
            shape_q <= OUT_W'(MID_SCALE);
            amp_q   <= '0;
            y       <= '0;
        end else if (en) begin
            shape_q <= shape;
            amp_q   <= amp;
            y       <= OUT_W'(prod >>> (AMP_W - 1));
        end
    end

endmodule

// File: rtl/mod_wave_gen.sv
// Phase-accumulator modulating source: saw/triangle/square/DC with amplitude scaling.
// Config is handshaked into a shadow and applied at a phase wrap, phase_clr or while stopped.
module mod_wave_gen #(
    parameter int PHASE_W = mod_wave_gen_pkg::PHASE_W,
    parameter int OUT_W   = mod_wave_gen_pkg::OUT_W,
    parameter int AMP_W   = mod_wave_gen_pkg::AMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fmod,
    input  logic [1:0]         cfg_wave,
    input  logic [AMP_W-1:0]   cfg_amp,
    output logic [OUT_W-1:0]   mod_out,
    output logic               mod_valid,
    output logic               wrap
);
    import mod_wave_gen_pkg::*;

    // Handshake: a config word transfers on a cycle where cfg_valid and cfg_ready
    // are both high; the word must stay stable while cfg_valid is high and unaccepted.

    cfg_state_t         state;
    cfg_state_t         state_nxt;
    logic               capture;
    logic               apply;
    logic               carry;
    logic [PHASE_W:0]   phase_sum;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] fmod_act;
    logic [PHASE_W-1:0] fmod_sh;
    logic [1:0]         wave_act;
    logic [1:0]         wave_sh;
    logic [AMP_W-1:0]   amp_act;
    logic [AMP_W-1:0]   amp_sh;
    logic [AMP_W-1:0]   amp_sat;
    logic [2:0]         valid_sr;
    logic [OUT_W-1:0]   y;

    assign phase_sum = {1'b0, phase} + {1'b0, fmod_act};
    assign carry     = en & ~phase_clr & phase_sum[PHASE_W];
    assign amp_sat   = (cfg_amp > AMP_W'(AMP_UNITY)) ? AMP_W'(AMP_UNITY) : cfg_amp;
    assign mod_valid = valid_sr[2];

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state)
            CFG_IDLE: begin
                cfg_ready = ~rst;
                if (cfg_valid && !rst) begin
                    capture   = 1'b1;
                    state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                // A capture on a wrap cycle lands here one cycle late, so it waits for the next wrap.
                if (carry || phase_clr || !en) begin
                    apply     = 1'b1;
                    state_nxt = CFG_IDLE;
                end
            end
            default: state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG_IDLE;
            phase    <= '0;
            fmod_act <= '0;
            wave_act <= WAVE_DC;
            amp_act  <= '0;
            fmod_sh  <= '0;
            wave_sh  <= WAVE_DC;
            amp_sh   <= '0;
            wrap     <= 1'b0;
            valid_sr <= '0;
            mod_out  <= OUT_W'(MID_SCALE);
        end else begin
            state <= state_nxt;
            if (capture) begin
                fmod_sh <= cfg_fmod;
                wave_sh <= cfg_wave;
                amp_sh  <= amp_sat;
            end
            if (apply) begin
                fmod_act <= fmod_sh;
                wave_act <= wave_sh;
                amp_act  <= amp_sh;
            end
            if (phase_clr) begin
                phase <= '0;
            end else if (en) begin
                phase <= phase_sum[PHASE_W-1:0];
            end
            wrap     <= carry;
            valid_sr <= {valid_sr[1:0], en};
            if (en) begin
                mod_out <= y + OUT_W'(MID_SCALE);
            end
        end
    end

    mod_wave_shape #(
        .OUT_W(OUT_W),
        .AMP_W(AMP_W)
    ) u_shape (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .phase_hi (phase[PHASE_W-1 -: OUT_W+1]),
        .wave     (wave_act),
        .amp      (amp_act),
        .y        (y)
    );

endmodule

// File: tb/tb_mod_wave_gen.sv
// Directed bench for mod_wave_gen: hand-computed waveform sequences, config timing,
// amplitude saturation, stall, phase clear and reset behaviour.
module tb_mod_wave_gen;

    localparam logic [1:0] W_DC  = 2'd0;
    localparam logic [1:0] W_SAW = 2'd1;
    localparam logic [1:0] W_TRI = 2'd2;
    localparam logic [1:0] W_SQR = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        phase_clr;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_fmod;
    logic [1:0]  cfg_wave;
    logic [13:0] cfg_amp;
    logic [13:0] mod_out;
    logic        mod_valid;
    logic        wrap;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mod_wave_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .phase_clr (phase_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_fmod  (cfg_fmod),
        .cfg_wave  (cfg_wave),
        .cfg_amp   (cfg_amp),
        .mod_out   (mod_out),
        .mod_valid (mod_valid),
        .wrap      (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Load a config while stopped with phase held at zero; applies on the next edge.
    task automatic load_cfg(input logic [23:0] f, input logic [1:0] w, input logic [13:0] a);
        en        = 1'b0;
        phase_clr = 1'b1;
        cfg_valid = 1'b1;
        cfg_fmod  = f;
        cfg_wave  = w;
        cfg_amp   = a;
        tick();
        cfg_valid = 1'b0;
        check("cfg_busy", 32'(cfg_ready), 32'd0);
        tick();
        phase_clr = 1'b0;
        check("cfg_idle", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        phase_clr = 1'b0;
        cfg_valid = 1'b0;
        cfg_fmod  = '0;
        cfg_wave  = W_DC;
        cfg_amp   = '0;
        tick();
        tick();
        check("rst_mod_out", 32'(mod_out), 32'h2000);
        check("rst_mod_valid", 32'(mod_valid), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(cfg_ready), 32'd1);

        // Sawtooth at unity: 0x400 per sample, period 16, wrap after the 16th step.
        load_cfg(24'h100000, W_SAW, 14'd8192);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("saw_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
            if (i >= 2) begin
                check("saw_out", 32'(mod_out), 32'(((i - 2) % 16) * 'h400));
                check("saw_valid", 32'(mod_valid), 32'd1);
            end
        end

        // Square at half amplitude.
        load_cfg(24'h100000, W_SQR, 14'd4096);
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i >= 2) begin
                check("sqr_out", 32'(mod_out), ((i - 2) < 8) ? 32'h2FFF : 32'h1000);
                check("sqr_valid", 32'(mod_valid), 32'd1);
            end
        end

        // Triangle at unity.
        load_cfg(24'h100000, W_TRI, 14'd8192);
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i >= 2) begin
                check("tri_out", 32'(mod_out),
                      ((i - 2) < 8) ? 32'('h800 * (i - 2)) : 32'('h3FFF - 'h800 * (i - 10)));
            end
        end

        // Mid-period config offer on a running saw applies at the next wrap.
        load_cfg(24'h100000, W_SAW, 14'd8192);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cfg_valid = 1'b1;
        cfg_fmod  = 24'h100000;
        cfg_wave  = W_DC;
        cfg_amp   = 14'd8192;
        tick();
        cfg_valid = 1'b0;
        check("mid_ready_low", 32'(cfg_ready), 32'd0);
        for (int i = 6; i < 15; i++) tick();
        check("mid_ready_still_low", 32'(cfg_ready), 32'd0);
        check("mid_no_wrap", 32'(wrap), 32'd0);
        tick();
        check("mid_ready_back", 32'(cfg_ready), 32'd1);
        check("mid_wrap", 32'(wrap), 32'd1);
        tick();
        tick();
        check("mid_last_saw", 32'(mod_out), 32'h3C00);
        tick();
        check("mid_first_dc", 32'(mod_out), 32'h2000);

        // Over-unity amplitude saturates to unity.
        load_cfg(24'h100000, W_SAW, 14'h3FFF);
        en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i >= 2) check("sat_out", 32'(mod_out), 32'((i - 2) * 'h400));
        end

        // DC ignores amplitude.
        load_cfg(24'h100000, W_DC, 14'h1234);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 2) check("dc_out", 32'(mod_out), 32'h2000);
        end

        // Zero amplitude gives midscale for every shape.
        for (int w = 1; w < 4; w++) begin
            load_cfg(24'h100000, 2'(w), 14'd0);
            en = 1'b1;
            for (int i = 0; i < 14; i++) begin
                tick();
                if (i >= 2) check("amp0_out", 32'(mod_out), 32'h2000);
            end
        end

        // Stall: mod_out holds, mod_valid drains after three edges, then resumes.
        load_cfg(24'h100000, W_SAW, 14'd8192);
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("pre_stall_out", 32'(mod_out), 32'h0C00);
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stall_hold", 32'(mod_out), 32'h0C00);
            check("stall_valid", 32'(mod_valid), (i <= 2) ? 32'd1 : 32'd0);
            check("stall_wrap", 32'(wrap), 32'd0);
        end
        en = 1'b1;
        tick();
        check("resume_first", 32'(mod_out), 32'h1000);
        tick();
        tick();
        check("resume_out", 32'(mod_out), 32'h1800);
        check("resume_valid", 32'(mod_valid), 32'd1);

        // phase_clr force-applies a pending config with no wrap pulse.
        cfg_valid = 1'b1;
        cfg_fmod  = 24'h100000;
        cfg_wave  = W_SQR;
        cfg_amp   = 14'd8192;
        tick();
        cfg_valid = 1'b0;
        check("clr_pending", 32'(cfg_ready), 32'd0);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("clr_applied", 32'(cfg_ready), 32'd1);
        check("clr_no_wrap", 32'(wrap), 32'd0);
        tick();
        check("clr_no_wrap2", 32'(wrap), 32'd0);
        tick();
        check("clr_old_sample", 32'(mod_out), 32'h2800);
        tick();
        check("clr_new_sample", 32'(mod_out), 32'h3FFF);

        // Reset with a config pending discards it.
        cfg_valid = 1'b1;
        cfg_fmod  = 24'h200000;
        cfg_wave  = W_TRI;
        cfg_amp   = 14'd100;
        tick();
        cfg_valid = 1'b0;
        check("rst_pend_busy", 32'(cfg_ready), 32'd0);
        en  = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_mod_out", 32'(mod_out), 32'h2000);
        check("midrst_valid", 32'(mod_valid), 32'd0);
        check("midrst_wrap", 32'(wrap), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_back", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_idle_out", 32'(mod_out), 32'h2000);
            check("midrst_idle_wrap", 32'(wrap), 32'd0);
        end
        check("midrst_valid_run", 32'(mod_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
